complex_unit: RTL and testbench

COMPLEX_UNIT -- requirements
Module: complex_unit

---
 rtl/complex_unit_if.sv | 21 ++
 rtl/complex_unit.sv | 174 +++++++++++++++++
 tb/tb_complex_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/complex_unit_if.sv
// rtl/complex_unit_if.sv - request/writeback bundle between core pipeline and complex_unit
interface complex_unit_if;
    logic        flush_i;
    logic        cu_valid_i;
    logic [2:0]  cu_opcode_i;
    logic [31:0] cu_operand1_i;
    logic [31:0] cu_operand2_i;
    logic        busy_o;
    logic [31:0] result_o;
    logic        wb_valid_o;

    modport master (
        output flush_i, cu_valid_i, cu_opcode_i, cu_operand1_i, cu_operand2_i,
        input  busy_o, result_o, wb_valid_o
    );

    modport slave (
        input  flush_i, cu_valid_i, cu_opcode_i, cu_operand1_i, cu_operand2_i,
        output busy_o, result_o, wb_valid_o
    );
endinterface

// File: rtl/complex_unit.sv
// rtl/complex_unit.sv - RV32M multiply/divide unit (optional COMPLEX_UNIT_DIV_EARLY_OUT_EN)
module complex_unit (
    input  logic          cpu_clk_i,
    input  logic          rst_i,
    complex_unit_if.slave cu_bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_div;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic        r_ovf;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_is_div;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_b_zero;
    logic        w_ovf;
    logic        w_busy;
    logic        w_wb_valid;

    logic signed [32:0] w_mul_a;
    logic signed [32:0] w_mul_b;
    logic signed [63:0] w_prod;
    logic [31:0] w_mul_res;

    logic [32:0] w_trial;
    logic [32:0] w_sub;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    // Request decode: opcode bit 2 selects divide, bit 0 clear marks signed divide
    assign w_accept     = (r_state == IDLE) && cu_bus.cu_valid_i && !cu_bus.flush_i;
    assign w_is_div     = cu_bus.cu_opcode_i[2];
    assign w_div_signed = w_is_div && !cu_bus.cu_opcode_i[0];
    assign w_a_neg      = w_div_signed && cu_bus.cu_operand1_i[31];
    assign w_b_neg      = w_div_signed && cu_bus.cu_operand2_i[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - cu_bus.cu_operand1_i) : cu_bus.cu_operand1_i;
    assign w_b_mag      = w_b_neg ? (32'd0 - cu_bus.cu_operand2_i) : cu_bus.cu_operand2_i;
    assign w_b_zero     = (cu_bus.cu_operand2_i == 32'd0);
    assign w_ovf        = w_div_signed && (cu_bus.cu_operand1_i == 32'h8000_0000)
                          && (cu_bus.cu_operand2_i == 32'hFFFF_FFFF);

    // Multiply: rs1 signed for MULH/MULHSU, rs2 signed only for MULH; MUL low half is sign-agnostic
    assign w_mul_a   = {((r_op == 2'b01) || (r_op == 2'b10)) && r_a[31], r_a};
    assign w_mul_b   = {(r_op == 2'b01) && r_b[31], r_b};
    assign w_prod    = 64'(w_mul_a) * 64'(w_mul_b);
    assign w_mul_res = (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    // One restoring step: shift next dividend bit in, keep difference when no borrow
    assign w_trial = {r_rem, r_quo[31]};
    assign w_sub   = w_trial - {1'b0, r_div};

    // Sign fixup, with divide-by-zero and signed overflow forced to their architectural values
    assign w_q_fix = r_div_zero ? 32'hFFFF_FFFF :
                     r_ovf      ? 32'h8000_0000 :
                     r_neg_q    ? (32'd0 - r_quo) : r_quo;
    assign w_r_fix = r_div_zero ? r_a :
                     r_ovf      ? 32'd0 :
                     r_neg_r    ? (32'd0 - r_rem) : r_rem;

    // State register; reset outranks flush
    always_ff @(posedge cpu_clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; flush returns to IDLE and masks a pending writeback
    always_comb begin
        w_next_state = r_state;
        w_busy       = (r_state != IDLE);
        w_wb_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_is_div ? DIV : MUL;
                end
            end
            MUL: w_next_state = FIX;
            DIV: begin
                if (r_cnt == 6'd32) begin
                    w_next_state = FIX;
                end
            end
            FIX: begin
                w_next_state = IDLE;
                w_wb_valid   = !cu_bus.flush_i && !rst_i;
            end
            default: w_next_state = IDLE;
        endcase
        if (cu_bus.flush_i) begin
            w_next_state = IDLE;
        end
    end

    // Operand capture, divide iterations, and result formation
    always_ff @(posedge cpu_clk_i) begin
        if (rst_i) begin
            r_cnt      <= 6'd0;
            r_op       <= 2'b00;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_div      <= 32'd0;
            r_quo      <= 32'd0;
            r_rem      <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_result   <= 32'd0;
        end else if (w_accept) begin
            r_op       <= cu_bus.cu_opcode_i[1:0];
            r_a        <= cu_bus.cu_operand1_i;
            r_b        <= cu_bus.cu_operand2_i;
            r_div      <= w_b_mag;
            r_quo      <= w_a_mag;
            r_rem      <= 32'd0;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= w_is_div && w_b_zero;
            r_ovf      <= w_ovf;
`ifdef COMPLEX_UNIT_DIV_EARLY_OUT_EN
            // Special-case divides jump straight to the fixup count
            r_cnt      <= (w_is_div && (w_b_zero || w_ovf)) ? 6'd32 : 6'd0;
`else
            r_cnt      <= 6'd0;
`endif
        end else if (cu_bus.flush_i) begin
            r_cnt <= 6'd0;
        end else begin
            case (r_state)
                MUL: r_result <= w_mul_res;
                DIV: begin
                    if (r_cnt == 6'd32) begin
                        r_result <= r_op[1] ? w_r_fix : w_q_fix;
                        r_cnt    <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (!w_sub[32]) begin
                            r_rem <= w_sub[31:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end else begin
                            r_rem <= w_trial[31:0];
                            r_quo <= {r_quo[30:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cu_bus.busy_o     = w_busy;
    assign cu_bus.wb_valid_o = w_wb_valid;
    assign cu_bus.result_o   = w_wb_valid ? r_result : 32'd0;
endmodule

// File: tb/tb_complex_unit.sv
// tb/tb_complex_unit.sv - directed self-checking bench for complex_unit
module tb_complex_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n_wb;

`ifdef COMPLEX_UNIT_DIV_EARLY_OUT_EN
    localparam int DIV_SPECIAL_LAT = 2;
`else
    localparam int DIV_SPECIAL_LAT = 34;
`endif

    complex_unit_if cu ();

    complex_unit dut (
        .cpu_clk_i (clk),
        .rst_i     (rst),
        .cu_bus    (cu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cu.wb_valid_o === 1'b1) n_wb <= n_wb + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        cu.cu_valid_i    = 1'b1;
        cu.cu_opcode_i   = op;
        cu.cu_operand1_i = a;
        cu.cu_operand2_i = b;
        @(posedge clk);
        #1;
        cu.cu_valid_i = 1'b0;
    endtask

    task automatic wait_wb(output int lat);
        lat = 1;
        while (cu.wb_valid_o !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(op, a, b);
        check({tag, "_busy_start"}, 32'(cu.busy_o), 32'd1);
        wait_wb(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, cu.result_o, exp_res);
        check({tag, "_busy_wb"}, 32'(cu.busy_o), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_wb_single"}, 32'(cu.wb_valid_o), 32'd0);
        check({tag, "_idle"}, 32'(cu.busy_o), 32'd0);
    endtask

    initial begin
        int wb0;
        n_checks = 0;
        n_pass   = 0;
        n_wb     = 0;
        rst = 1'b1;
        cu.flush_i       = 1'b0;
        cu.cu_valid_i    = 1'b0;
        cu.cu_opcode_i   = 3'd0;
        cu.cu_operand1_i = 32'd0;
        cu.cu_operand2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(cu.busy_o), 32'd0);
        check("rst_wb", 32'(cu.wb_valid_o), 32'd0);
        check("rst_result", cu.result_o, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        run_op("mul_neg",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        run_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_op("mulhu",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run_op("div_20_m6",  3'b100, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 34);
        run_op("rem_20_m6",  3'b110, 32'd20,        32'hFFFF_FFFA, 32'd2,         34);
        run_op("divu_big",   3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34);
        run_op("remu_big",   3'b111, 32'hFFFF_FFF9, 32'd2,         32'd1,         34);
        run_op("divu_z",     3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, DIV_SPECIAL_LAT);
        run_op("remu_z",     3'b111, 32'd100,       32'd0,         32'd100,       DIV_SPECIAL_LAT);
        run_op("div_z",      3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, DIV_SPECIAL_LAT);
        run_op("rem_z",      3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, DIV_SPECIAL_LAT);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_SPECIAL_LAT);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DIV_SPECIAL_LAT);

        // Flush mid-divide, then an immediate multiply
        wb0 = n_wb;
        issue(3'b101, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #1;
        cu.flush_i = 1'b1;
        @(posedge clk);
        #1;
        cu.flush_i = 1'b0;
        check("flush_busy", 32'(cu.busy_o), 32'd0);
        run_op("post_flush_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        repeat (40) @(posedge clk);
        #1;
        check("flush_pulses", 32'(n_wb - wb0), 32'd1);

        // Flush during the writeback cycle suppresses the pulse
        wb0 = n_wb;
        issue(3'b000, 32'd3, 32'd5);
        @(posedge clk);
        #1;
        cu.flush_i = 1'b1;
        #1;
        check("flush_fix_wb", 32'(cu.wb_valid_o), 32'd0);
        check("flush_fix_res", cu.result_o, 32'd0);
        @(posedge clk);
        #1;
        cu.flush_i = 1'b0;
        check("flush_fix_busy", 32'(cu.busy_o), 32'd0);
        check("flush_fix_pulses", 32'(n_wb - wb0), 32'd0);

        // Request during MUL is ignored
        wb0 = n_wb;
        issue(3'b000, 32'd6, 32'd7);
        cu.cu_valid_i    = 1'b1;
        cu.cu_opcode_i   = 3'b100;
        cu.cu_operand1_i = 32'd50;
        cu.cu_operand2_i = 32'd5;
        @(posedge clk);
        #1;
        cu.cu_valid_i = 1'b0;
        check("ign_wb", 32'(cu.wb_valid_o), 32'd1);
        check("ign_result", cu.result_o, 32'd42);
        repeat (40) @(posedge clk);
        #1;
        check("ign_pulses", 32'(n_wb - wb0), 32'd1);
        check("ign_busy", 32'(cu.busy_o), 32'd0);

        // Reset during a divide
        wb0 = n_wb;
        issue(3'b100, 32'd12345, 32'd7);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        cu.flush_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cu.flush_i = 1'b0;
        check("rstdiv_busy", 32'(cu.busy_o), 32'd0);
        check("rstdiv_wb", 32'(cu.wb_valid_o), 32'd0);
        check("rstdiv_result", cu.result_o, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("rstdiv_pulses", 32'(n_wb - wb0), 32'd0);
        run_op("post_rst_div", 3'b100, 32'd12345, 32'd7, 32'd1763, 34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
